// File: rtl/imm_gen_pkg.sv
// Shared immediate-format encodings and default datapath width for the
// immediate generator slice.
package imm_gen_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;
    localparam logic [2:0] IMM_Z = 3'b101;

endpackage

// File: rtl/imm_gen_if.sv
// Valid/ready request and response bundle between an instruction source,
// the immediate generator, and the consumer of the extended immediate.
interface imm_gen_if #(
    parameter int XLEN = imm_gen_pkg::XLEN_DEF
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      ImmSrc;
    logic [31:7]     Instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] ImmExt;
    logic            illegal;

    modport master (
        output in_valid, ImmSrc, Instr, out_ready,
        input  in_ready, out_valid, ImmExt, illegal
    );

    modport slave (
        input  in_valid, ImmSrc, Instr, out_ready,
        output in_ready, out_valid, ImmExt, illegal
    );
endinterface

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate extraction and extension to XLEN bits.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2:0]      ImmSrc,
    input  logic [31:7]     Instr,
    output logic [XLEN-1:0] ImmExt,
    output logic            illegal
);

    // Size casts of signed operands sign-extend, which also covers U above bit 31.
    always_comb begin
        ImmExt  = '0;
        illegal = 1'b0;
        case (ImmSrc)
            IMM_I: ImmExt = XLEN'($signed(Instr[31:20]));
            IMM_S: ImmExt = XLEN'($signed({Instr[31:25], Instr[11:7]}));
            IMM_B: ImmExt = XLEN'($signed({Instr[31], Instr[7], Instr[30:25],
                                           Instr[11:8], 1'b0}));
            IMM_U: ImmExt = XLEN'($signed({Instr[31:12], 12'h000}));
            IMM_J: ImmExt = XLEN'($signed({Instr[31], Instr[19:12], Instr[20],
                                           Instr[30:21], 1'b0}));
            IMM_Z: ImmExt = XLEN'(Instr[19:15]);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a small result FIFO: decodes on accept, then
// presents the oldest decoded entry under valid/ready flow control.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     flush,
    imm_gen_if.slave bus
);

    logic [XLEN-1:0] mem_imm [DEPTH];
    logic            mem_ill [DEPTH];
    logic [0:0]      wr_ptr;
    logic [0:0]      rd_ptr;
    logic [1:0]      count;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] dec_imm;
    logic            dec_ill;

    function automatic logic [0:0] ptr_next(input logic [0:0] p);
        return (p == 1'(DEPTH - 1)) ? 1'b0 : p + 1'b1;
    endfunction

    imm_decode #(.XLEN(XLEN)) u_decode (
        .ImmSrc  (bus.ImmSrc),
        .Instr   (bus.Instr),
        .ImmExt  (dec_imm),
        .illegal (dec_ill)
    );

    // Ready depends on occupancy only, so out_ready never reaches in_ready.
    assign bus.in_ready  = (count < 2'(DEPTH));
    assign bus.out_valid = (count != 2'd0);
    assign bus.ImmExt    = mem_imm[rd_ptr];
    assign bus.illegal   = mem_ill[rd_ptr];

    assign push = bus.in_valid  && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            // Entries are cleared so the idle outputs read as zero after reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem_imm[i] <= '0;
                mem_ill[i] <= 1'b0;
            end
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                mem_imm[wr_ptr] <= dec_imm;
                mem_ill[wr_ptr] <= dec_ill;
                wr_ptr          <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule
